dh_matrix_gen: RTL and testbench

//  Builds the 4x4 Denavit-Hartenberg transform for one joint from precomputed sin/cos and link

---
 rtl/dh_matrix_gen_pkg.sv | 17 +
 rtl/dh_matrix_gen_fx_mul.sv | 40 ++++
 rtl/dh_matrix_gen.sv | 142 ++++++++++++++
 tb/tb_dh_matrix_gen.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dh_matrix_gen_pkg.sv
// Shared types for the inverse-kinematics datapath: fixed-point word, matrix view, FSM states.
// The element index helper gives the flat row-major position used by the packed out_mat bus.
package dh_matrix_gen_pkg;
  localparam int DH_W         = 36;
  localparam int DH_FRAC_BITS = 32;

  typedef logic signed [DH_W-1:0] fixed_t;
  typedef fixed_t mat4_t [4][4];

  localparam fixed_t FX_ONE = fixed_t'(64'd1 << DH_FRAC_BITS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} dh_state_t;

  function automatic int mat_idx(input int r, input int c);
    return 4 * r + c;
  endfunction
endpackage

// File: rtl/dh_matrix_gen_fx_mul.sv
// Signed fixed-point multiply: full 2W product, arithmetic shift by FRAC_BITS, keep low W bits.
// Latency MULT_LAT cycles; no backpressure, a result emerges every cycle an operand pair entered.
// Index travels alongside the product so the caller knows where to write it back.
module fx_mul #(
  parameter int W         = 36,
  parameter int FRAC_BITS = 32,
  parameter int MULT_LAT  = 1
) (
  input  logic                clk,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                valid_in,
  input  logic [2:0]          idx_in,
  output logic signed [W-1:0] p,
  output logic                valid_out,
  output logic [2:0]          idx_out
);
  logic signed [2*W-1:0] prod;
  logic signed [W-1:0]   p_q [MULT_LAT];
  logic                  v_q [MULT_LAT];
  logic [2:0]            i_q [MULT_LAT];

  assign prod = a * b;

  // >>> floors toward -inf; the width cast then wraps anything above W bits.
  always_ff @(posedge clk) begin
    p_q[0] <= W'(prod >>> FRAC_BITS);
    v_q[0] <= valid_in;
    i_q[0] <= idx_in;
    for (int s = 1; s < MULT_LAT; s++) begin
      p_q[s] <= p_q[s-1];
      v_q[s] <= v_q[s-1];
      i_q[s] <= i_q[s-1];
    end
  end

  assign p         = p_q[MULT_LAT-1];
  assign valid_out = v_q[MULT_LAT-1];
  assign idx_out   = i_q[MULT_LAT-1];
endmodule

// File: rtl/dh_matrix_gen.sv
// Builds one joint's 4x4 Denavit-Hartenberg transform; six products share a single fx_mul.
// Latency: input accept on edge k -> out_valid from edge k+7+MULT_LAT; one matrix in flight.
// Backpressure: out_valid/out_mat held until out_ready; in_ready only while idle.
module dh_matrix_gen
  import dh_matrix_gen_pkg::*;
#(
  parameter int W         = DH_W,
  parameter int FRAC_BITS = DH_FRAC_BITS,
  parameter int MULT_LAT  = 1,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [W-1:0]      cos_t,
  input  logic [W-1:0]      sin_t,
  input  logic [W-1:0]      cos_a,
  input  logic [W-1:0]      sin_a,
  input  logic [W-1:0]      link_a,
  input  logic [W-1:0]      link_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [16*W-1:0]   out_mat
);
  localparam logic [W-1:0] ONE = W'(1) << FRAC_BITS;
  localparam int           DCW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  dh_state_t state, state_d;
  logic [2:0]     issue_cnt;
  logic [DCW-1:0] drain_cnt;

  logic signed [W-1:0] op_ct, op_st, op_ca, op_sa, op_a;
  logic signed [W-1:0] mul_a, mul_b, mul_p;
  logic                mul_vld_in, mul_vld;
  logic [2:0]          mul_idx;
  logic [16*W-1:0]     mat_init;
  logic                accept, wb_en;

  assign accept     = in_valid && in_ready;
  assign mul_vld_in = (state == ISSUE);
  // Results still in the multiplier pipe after an abort must not land in a later matrix.
  assign wb_en      = mul_vld && (state == ISSUE || state == DRAIN);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (issue_cnt)
      3'd0: begin mul_a = op_ct; mul_b = op_ca; end
      3'd1: begin mul_a = op_st; mul_b = op_ca; end
      3'd2: begin mul_a = op_ct; mul_b = op_sa; end
      3'd3: begin mul_a = op_st; mul_b = op_sa; end
      3'd4: begin mul_a = op_a;  mul_b = op_ct; end
      3'd5: begin mul_a = op_a;  mul_b = op_st; end
      default: ;
    endcase
  end

  fx_mul #(.W(W), .FRAC_BITS(FRAC_BITS), .MULT_LAT(MULT_LAT)) u_mul (
    .clk      (clk),
    .a        (mul_a),
    .b        (mul_b),
    .valid_in (mul_vld_in),
    .idx_in   (issue_cnt),
    .p        (mul_p),
    .valid_out(mul_vld),
    .idx_out  (mul_idx)
  );

  // Pass-through and constant elements are fixed at accept; product slots start at zero.
  always_comb begin
    mat_init = '0;
    mat_init[mat_idx(0, 0)*W +: W] = cos_t;
    mat_init[mat_idx(1, 0)*W +: W] = sin_t;
    mat_init[mat_idx(2, 1)*W +: W] = sin_a;
    mat_init[mat_idx(2, 2)*W +: W] = cos_a;
    mat_init[mat_idx(2, 3)*W +: W] = link_d;
    mat_init[mat_idx(3, 3)*W +: W] = ONE;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: if (issue_cnt == 3'd5) state_d = DRAIN;
      DRAIN: if (drain_cnt == DCW'(MULT_LAT - 1)) state_d = OUT;
      OUT:   if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_mat   <= '0;
      issue_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == IDLE);
      issue_cnt <= (state == ISSUE) ? issue_cnt + 3'd1 : 3'd0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

      if (out_valid && out_ready)
        out_valid <= 1'b0;
      else if (state == OUT)
        out_valid <= 1'b1;

      if (accept) begin
        out_tag <= in_tag;
        out_mat <= mat_init;
      end

      if (wb_en) begin
        case (mul_idx)
          3'd0: out_mat[mat_idx(1, 1)*W +: W] <= mul_p;
          3'd1: out_mat[mat_idx(0, 1)*W +: W] <= -mul_p;
          3'd2: out_mat[mat_idx(1, 2)*W +: W] <= -mul_p;
          3'd3: out_mat[mat_idx(0, 2)*W +: W] <= mul_p;
          3'd4: out_mat[mat_idx(0, 3)*W +: W] <= mul_p;
          3'd5: out_mat[mat_idx(1, 3)*W +: W] <= mul_p;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_ct <= cos_t;
      op_st <= sin_t;
      op_ca <= cos_a;
      op_sa <= sin_a;
      op_a  <= link_a;
    end
  end
endmodule

// File: tb/tb_dh_matrix_gen.sv
// Directed bench for dh_matrix_gen: hand-computed Q3.32 matrices, latency, backpressure, reset.
module tb_dh_matrix_gen;
  localparam int W = 36;

  localparam logic [35:0] Z    = 36'h0_0000_0000;
  localparam logic [35:0] ONE  = 36'h1_0000_0000;
  localparam logic [35:0] NEG1 = 36'hF_0000_0000;
  localparam logic [35:0] TWO  = 36'h2_0000_0000;
  localparam logic [35:0] HALF = 36'h0_8000_0000;
  localparam logic [35:0] QNEG = 36'hF_C000_0000;
  localparam logic [35:0] LSBN = 36'hF_FFFF_FFFF;
  localparam logic [35:0] LSBP = 36'h0_0000_0001;
  localparam logic [35:0] MINV = 36'h8_0000_0000;

  logic            clk;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_tag;
  logic [W-1:0]    cos_t, sin_t, cos_a, sin_a, link_a, link_d;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_tag;
  logic [16*W-1:0] out_mat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dh_matrix_gen #(.W(W), .FRAC_BITS(32), .MULT_LAT(1), .TAG_W(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_tag   (in_tag),
    .cos_t    (cos_t),
    .sin_t    (sin_t),
    .cos_a    (cos_a),
    .sin_a    (sin_a),
    .link_a   (link_a),
    .link_d   (link_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_tag  (out_tag),
    .out_mat  (out_mat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4*W-1:0] row(input logic [35:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [16*W-1:0] mat(input logic [4*W-1:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [16*W-1:0] ident();
    return mat(row(ONE, Z, Z, Z), row(Z, ONE, Z, Z), row(Z, Z, ONE, Z), row(Z, Z, Z, ONE));
  endfunction

  function automatic logic [16*W-1:0] exp_theta90();
    return mat(row(Z, NEG1, Z, Z), row(ONE, Z, Z, TWO), row(Z, Z, ONE, HALF), row(Z, Z, Z, ONE));
  endfunction

  function automatic logic [16*W-1:0] exp_alpha90();
    return mat(row(ONE, Z, Z, ONE), row(Z, Z, NEG1, Z), row(Z, ONE, Z, QNEG), row(Z, Z, Z, ONE));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [35:0] ct, st, ca, sa, a, d, input logic [3:0] tag);
    cos_t = ct; sin_t = st; cos_a = ca; sin_a = sa; link_a = a; link_d = d; in_tag = tag;
  endtask

  task automatic accept_in(input logic [35:0] ct, st, ca, sa, a, d, input logic [3:0] tag);
    int n;
    n = 0;
    drive(ct, st, ca, sa, a, d, tag);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait: in_ready=%b after %0d cycles, need 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL out_wait: out_valid=%b after %0d cycles, need 1", out_valid, lat);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(Z, Z, Z, Z, Z, Z, 4'd0);
    repeat (3) tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
    total++;
    if (out_tag !== 4'd0) begin bad++; $display("FAIL rst_out_tag: got %0d need 0", out_tag); end
    total++;
    if (out_mat !== '0) begin bad++; $display("FAIL rst_out_mat: got %h need 0", out_mat); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_low: got %b need 0", in_ready); end
    reset_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_rel: got %b need 1", in_ready); end
  endtask

  task automatic test_identity();
    int lat;
    accept_in(ONE, Z, ONE, Z, Z, Z, 4'd3);
    wait_out(lat);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL id_latency: got %0d need 8", lat); end
    total++;
    if (out_tag !== 4'd3) begin bad++; $display("FAIL id_tag: got %0d need 3", out_tag); end
    total++;
    if (out_mat !== ident()) begin bad++; $display("FAIL id_mat: got %h need %h", out_mat, ident()); end
    handshake();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL id_release: out_valid=%b in_ready=%b need 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_theta90();
    int lat;
    accept_in(Z, ONE, ONE, Z, TWO, HALF, 4'd6);
    wait_out(lat);
    total++;
    if (out_mat !== exp_theta90()) begin
      bad++; $display("FAIL th90_mat: got %h need %h", out_mat, exp_theta90());
    end
    handshake();
  endtask

  task automatic test_alpha90();
    int lat;
    accept_in(ONE, Z, Z, ONE, ONE, QNEG, 4'd8);
    wait_out(lat);
    total++;
    if (out_mat !== exp_alpha90()) begin
      bad++; $display("FAIL al90_mat: got %h need %h", out_mat, exp_alpha90());
    end
    total++;
    if (out_tag !== 4'd8) begin bad++; $display("FAIL al90_tag: got %0d need 8", out_tag); end
    handshake();
  endtask

  task automatic test_truncation();
    int lat;
    logic [16*W-1:0] e;
    // (-2^-32)^2 = +2^-64 floors to 0.
    accept_in(LSBN, Z, LSBN, Z, Z, Z, 4'd1);
    wait_out(lat);
    e = mat(row(LSBN, Z, Z, Z), row(Z, Z, Z, Z), row(Z, Z, LSBN, Z), row(Z, Z, Z, ONE));
    total++;
    if (out_mat !== e) begin bad++; $display("FAIL trunc_pos: got %h need %h", out_mat, e); end
    handshake();
    // -2^-32 * 0.5 floors to -2^-32; its negation is +2^-32.
    accept_in(LSBN, LSBN, HALF, Z, Z, Z, 4'd2);
    wait_out(lat);
    e = mat(row(LSBN, LSBP, Z, Z), row(LSBN, LSBN, Z, Z), row(Z, Z, HALF, Z), row(Z, Z, Z, ONE));
    total++;
    if (out_mat !== e) begin bad++; $display("FAIL trunc_floor: got %h need %h", out_mat, e); end
    handshake();
    // -(MIN * 1.0) wraps back to MIN.
    accept_in(Z, MINV, ONE, Z, ONE, Z, 4'd4);
    wait_out(lat);
    e = mat(row(Z, MINV, Z, Z), row(MINV, Z, Z, MINV), row(Z, Z, ONE, Z), row(Z, Z, Z, ONE));
    total++;
    if (out_mat !== e) begin bad++; $display("FAIL neg_wrap: got %h need %h", out_mat, e); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    accept_in(Z, ONE, ONE, Z, TWO, HALF, 4'd5);
    wait_out(lat);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      drive(LSBN, MINV, TWO, ONE, NEG1, QNEG, 4'd9);
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_tag !== 4'd5 || out_mat !== exp_theta90()) begin
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b tag=%0d mat=%h need 1/0/5/%h",
                 i, out_valid, in_ready, out_tag, out_mat, exp_theta90());
      end
    end
    in_valid = 1'b0;
    handshake();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
    end
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL bp_no_accept: got %0d valid cycles need 0", seen); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    accept_in(ONE, Z, Z, ONE, ONE, QNEG, 4'd7);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_mat !== '0 || out_tag !== 4'd0) begin
      bad++;
      $display("FAIL mid_rst: valid=%b in_ready=%b tag=%0d mat=%h need 0/0/0/0",
               out_valid, in_ready, out_tag, out_mat);
    end
    reset_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b need 1", in_ready); end
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL mid_rst_abort: got %0d valid cycles need 0", seen); end
    accept_in(Z, ONE, ONE, Z, TWO, HALF, 4'd4);
    wait_out(lat);
    total++;
    if (lat !== 8 || out_tag !== 4'd4 || out_mat !== exp_theta90()) begin
      bad++;
      $display("FAIL mid_rst_next: lat=%0d tag=%0d mat=%h need 8/4/%h",
               lat, out_tag, out_mat, exp_theta90());
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int n_acc;
    int n_out;
    int cyc_at [2];
    logic [3:0] tags [2];
    logic [16*W-1:0] mats [2];
    logic acc;
    n_acc = 0;
    n_out = 0;
    out_ready = 1'b1;
    drive(ONE, Z, ONE, Z, Z, Z, 4'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc == 1) drive(ONE, Z, Z, ONE, ONE, QNEG, 4'd2);
        else in_valid = 1'b0;
      end
      if (out_valid && n_out < 2) begin
        tags[n_out]   = out_tag;
        mats[n_out]   = out_mat;
        cyc_at[n_out] = cyc;
        n_out++;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (n_out !== 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d outputs need 2", n_out);
    end else begin
      total++;
      if (tags[0] !== 4'd1 || tags[1] !== 4'd2) begin
        bad++; $display("FAIL b2b_order: got tags %0d,%0d need 1,2", tags[0], tags[1]);
      end
      total++;
      if (cyc_at[1] - cyc_at[0] !== 10) begin
        bad++; $display("FAIL b2b_spacing: got %0d cycles need 10", cyc_at[1] - cyc_at[0]);
      end
      total++;
      if (mats[0] !== ident() || mats[1] !== exp_alpha90()) begin
        bad++;
        $display("FAIL b2b_mats: got %h / %h need identity / alpha90", mats[0], mats[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_theta90();
    test_alpha90();
    test_truncation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
